// File: rtl/rvfi_gen_pkg.sv
// Shared types and constants for the RVFI PC/order retirement-stream generator.
package rvfi_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        F_NONE  = 2'd0,
        F_PCGAP = 2'd1,
        F_SKIP  = 2'd2,
        F_DUP   = 2'd3
    } fault_e;

    localparam int unsigned STEP_SHORT = 32'd2;
    localparam int unsigned STEP_FULL  = 32'd4;
    localparam int unsigned STEP_GAP   = 32'd8;

endpackage

// File: rtl/rvfi_gen_lane.sv
// One retirement lane: turns an incoming PC into pc_rdata/pc_wdata, applying the
// sequential step or an aligned redirect target.
module rvfi_gen_lane
    import rvfi_gen_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned COMPRESSED = 0
) (
    input  logic [XLEN-1:0] i_pc_in,
    input  logic            i_short_step,
    input  logic            i_jump,
    input  logic [XLEN-1:0] i_jump_target,
    output logic [XLEN-1:0] o_pc_rdata,
    output logic [XLEN-1:0] o_pc_wdata
);

    // Without compressed support, targets are forced to 4-byte alignment.
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, (COMPRESSED != 0), 1'b0};

    // Next-PC selection: redirect wins over the sequential step.
    always_comb begin
        o_pc_rdata = i_pc_in;
        if (i_jump) begin
            o_pc_wdata = i_jump_target & ALIGN_MASK;
        end else if ((COMPRESSED != 0) && i_short_step) begin
            o_pc_wdata = i_pc_in + XLEN'(STEP_SHORT);
        end else begin
            o_pc_wdata = i_pc_in + XLEN'(STEP_FULL);
        end
    end

endmodule

// File: rtl/rvfi_pc_seq_gen.sv
// RVFI PC/order retirement-stream generator: up to NRET in-order retirements per
// cycle with a consistent PC chain and one-shot fault injection, standing in for a core.
module rvfi_pc_seq_gen
    import rvfi_gen_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     NRET       = 2,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     MAX_INSN   = 64,
    parameter int unsigned     COMPRESSED = 0
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       start,
    input  logic                       stall,
    input  logic [$clog2(NRET+1)-1:0]  lanes_req,
    input  logic [NRET-1:0]            short_step,
    input  logic                       jump_req,
    input  logic [XLEN-1:0]            jump_target,
    input  logic [1:0]                 fault_sel,
    input  logic                       fault_arm,
    output logic [NRET-1:0]            rvfi_valid,
    output logic [64*NRET-1:0]         rvfi_order,
    output logic [XLEN*NRET-1:0]       rvfi_pc_rdata,
    output logic [XLEN*NRET-1:0]       rvfi_pc_wdata,
    output logic [NRET-1:0]            rvfi_halt,
    output logic                       done
);

    localparam logic [31:0] MAX_CNT    = 32'(MAX_INSN);
    localparam logic [63:0] HALT_ORDER = 64'(MAX_INSN) - 64'd1;

    state_e                r_state, w_state_nxt;
    fault_e                r_fault, w_fault_nxt;
    logic [XLEN-1:0]       r_pc, w_pc_nxt, w_pc_base, w_pc_last;
    logic [63:0]           r_order, w_order_nxt, w_lane_order;
    logic [31:0]           r_count, w_count_nxt, w_remain, w_req, w_k;
    logic                  w_emit;
    logic [XLEN*NRET-1:0]  w_rdata_all, w_wdata_all;
    logic [NRET-1:0]       r_valid, w_valid_nxt, r_halt, w_halt_nxt;
    logic [64*NRET-1:0]    r_order_out, w_order_out_nxt;
    logic [XLEN*NRET-1:0]  r_rdata, w_rdata_nxt, r_wdata, w_wdata_nxt;
    logic                  r_done;

    // Group size: request clamped to the lane count and to the remaining budget.
    always_comb begin
        w_remain  = MAX_CNT - r_count;
        w_req     = (32'(lanes_req) > 32'(NRET)) ? 32'(NRET) : 32'(lanes_req);
        w_k       = (w_req > w_remain) ? w_remain : w_req;
        w_emit    = (r_state == RUN) && !stall && (w_k != 32'd0);
        w_pc_base = (r_fault == F_PCGAP) ? (r_pc + XLEN'(STEP_GAP)) : r_pc;
    end

    for (genvar i = 0; i < NRET; i++) begin : g_lane
        logic [XLEN-1:0] w_pc_in, w_rd, w_wd;
        logic            w_jump;
        if (i == 0) begin : g_head
            assign w_pc_in = w_pc_base;
        end else begin : g_link
            assign w_pc_in = g_lane[i-1].w_wd;
        end
        assign w_jump = jump_req && ((32'(i) + 32'd1) == w_k);
        rvfi_gen_lane #(.XLEN(XLEN), .COMPRESSED(COMPRESSED)) u_lane (
            .i_pc_in       (w_pc_in),
            .i_short_step  (short_step[i]),
            .i_jump        (w_jump),
            .i_jump_target (jump_target),
            .o_pc_rdata    (w_rd),
            .o_pc_wdata    (w_wd)
        );
        assign w_rdata_all[i*XLEN +: XLEN] = w_rd;
        assign w_wdata_all[i*XLEN +: XLEN] = w_wd;
    end

    // Per-lane output fields; lanes past the group size stay zero.
    always_comb begin
        w_valid_nxt     = '0;
        w_halt_nxt      = '0;
        w_order_out_nxt = '0;
        w_rdata_nxt     = '0;
        w_wdata_nxt     = '0;
        w_pc_last       = r_pc;
        w_lane_order    = 64'd0;
        for (int i = 0; i < NRET; i++) begin
            w_lane_order = r_order + 64'(i) + ((r_fault == F_SKIP) ? 64'd1 : 64'd0);
            w_lane_order = ((i == 0) && (r_fault == F_DUP)) ? (r_order - 64'd1) : w_lane_order;
            if (w_emit && (32'(i) < w_k)) begin
                w_valid_nxt[i]                = 1'b1;
                w_halt_nxt[i]                 = (w_lane_order == HALT_ORDER);
                w_order_out_nxt[i*64 +: 64]   = w_lane_order;
                w_rdata_nxt[i*XLEN +: XLEN]   = w_rdata_all[i*XLEN +: XLEN];
                w_wdata_nxt[i*XLEN +: XLEN]   = w_wdata_all[i*XLEN +: XLEN];
                w_pc_last                     = w_wdata_all[i*XLEN +: XLEN];
            end else begin
                w_valid_nxt[i] = 1'b0;
            end
        end
    end

    // FSM next state plus PC/order/count/fault bookkeeping.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_order_nxt = r_order;
        w_count_nxt = r_count;
        w_fault_nxt = r_fault;
        case (r_state)
            IDLE:    w_state_nxt = start ? RUN : IDLE;
            RUN:     w_state_nxt = (w_emit && ((r_count + w_k) == MAX_CNT)) ? HALT : RUN;
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = IDLE;
        endcase
        if (w_emit) begin
            w_pc_nxt    = w_pc_last;
            w_order_nxt = r_order + 64'(w_k)
                        + ((r_fault == F_SKIP) ? 64'd1 : 64'd0)
                        - ((r_fault == F_DUP)  ? 64'd1 : 64'd0);
            w_count_nxt = r_count + w_k;
        end else begin
            w_pc_nxt = r_pc;
        end
        // A new arm taken alongside an emission targets the following group.
        if (fault_arm) begin
            w_fault_nxt = fault_e'(fault_sel);
        end else if (w_emit) begin
            w_fault_nxt = F_NONE;
        end else begin
            w_fault_nxt = r_fault;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_fault     <= F_NONE;
            r_pc        <= RESET_PC;
            r_order     <= 64'd0;
            r_count     <= 32'd0;
            r_valid     <= '0;
            r_halt      <= '0;
            r_order_out <= '0;
            r_rdata     <= '0;
            r_wdata     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fault     <= w_fault_nxt;
            r_pc        <= w_pc_nxt;
            r_order     <= w_order_nxt;
            r_count     <= w_count_nxt;
            r_valid     <= w_valid_nxt;
            r_halt      <= w_halt_nxt;
            r_order_out <= w_order_out_nxt;
            r_rdata     <= w_rdata_nxt;
            r_wdata     <= w_wdata_nxt;
            r_done      <= (w_state_nxt == HALT);
        end
    end

    assign rvfi_valid    = r_valid;
    assign rvfi_order    = r_order_out;
    assign rvfi_pc_rdata = r_rdata;
    assign rvfi_pc_wdata = r_wdata;
    assign rvfi_halt     = r_halt;
    assign done          = r_done;

endmodule

// File: tb/tb_rvfi_pc_seq_gen.sv
// Bench for rvfi_pc_seq_gen: directed scenarios plus random traffic against a
// lane-by-lane reference model of the retirement stream.
module tb_rvfi_pc_seq_gen;

    localparam int MAXI = 13;

    logic         clock = 1'b0;
    logic         resetn, start, stall, jump_req, fault_arm;
    logic [1:0]   lanes_req, short_step, fault_sel;
    logic [31:0]  jump_target;
    logic [1:0]   rvfi_valid, rvfi_halt;
    logic [127:0] rvfi_order;
    logic [63:0]  rvfi_pc_rdata, rvfi_pc_wdata;
    logic         done;

    int vectors = 0;
    int miscompares = 0;

    int          m_state, m_count;
    logic [31:0] m_pc;
    logic [63:0] m_order;
    logic [1:0]  m_fault;
    logic [1:0]   exp_valid, exp_halt;
    logic [127:0] exp_order;
    logic [63:0]  exp_rd, exp_wd;
    logic         exp_done;

    wire [260:0] got = {rvfi_valid, rvfi_halt, done, rvfi_order, rvfi_pc_rdata, rvfi_pc_wdata};

    rvfi_pc_seq_gen #(.XLEN(32), .NRET(2), .RESET_PC(32'h0), .MAX_INSN(MAXI), .COMPRESSED(0)) dut (
        .clock(clock), .resetn(resetn), .start(start), .stall(stall), .lanes_req(lanes_req),
        .short_step(short_step), .jump_req(jump_req), .jump_target(jump_target),
        .fault_sel(fault_sel), .fault_arm(fault_arm), .rvfi_valid(rvfi_valid),
        .rvfi_order(rvfi_order), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_halt(rvfi_halt), .done(done)
    );

    always #5 clock = ~clock;

    function automatic logic [260:0] pack_exp();
        return {exp_valid, exp_halt, exp_done, exp_order, exp_rd, exp_wd};
    endfunction

    // Predict the outputs for the current inputs, then advance one clock.
    task automatic apply();
        int k;
        logic [31:0] pc;
        logic [63:0] o;
        logic emitted;
        emitted = 1'b0;
        exp_valid = '0; exp_halt = '0; exp_order = '0; exp_rd = '0; exp_wd = '0;
        if (!resetn) begin
            m_state = 0; m_pc = 32'h0; m_order = 64'd0; m_count = 0; m_fault = 2'd0;
        end else begin
            if (m_state == 1 && !stall) begin
                k = int'(lanes_req);
                if (k > 2) k = 2;
                if (k > MAXI - m_count) k = MAXI - m_count;
                if (k > 0) begin
                    emitted = 1'b1;
                    pc = m_pc + ((m_fault == 2'd1) ? 32'd8 : 32'd0);
                    for (int i = 0; i < k; i++) begin
                        if (m_fault == 2'd3 && i == 0) o = m_order - 64'd1;
                        else o = m_order + 64'(i) + ((m_fault == 2'd2) ? 64'd1 : 64'd0);
                        exp_valid[i] = 1'b1;
                        exp_order[64*i +: 64] = o;
                        exp_rd[32*i +: 32] = pc;
                        pc = (jump_req && i == k - 1) ? (jump_target & ~32'd3) : pc + 32'd4;
                        exp_wd[32*i +: 32] = pc;
                        exp_halt[i] = (o == 64'(MAXI - 1));
                    end
                    m_pc = pc;
                    m_order = m_order + 64'(k) + ((m_fault == 2'd2) ? 64'd1 : 64'd0)
                            - ((m_fault == 2'd3) ? 64'd1 : 64'd0);
                    m_count = m_count + k;
                    if (m_count == MAXI) m_state = 2;
                end
            end else if (m_state == 0 && start) begin
                m_state = 1;
            end
            if (fault_arm) m_fault = fault_sel;
            else if (emitted) m_fault = 2'd0;
        end
        exp_done = (m_state == 2);
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; stall = 1'b0; lanes_req = 2'd0; short_step = 2'b00; jump_req = 1'b0;
        jump_target = 32'h0; fault_sel = 2'd0; fault_arm = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0; start = 1'b1; lanes_req = 2'd2;
        for (int c = 0; c < 2; c++) begin
            apply();
            vectors++;
            if (got !== 261'd0 || got !== pack_exp()) begin
                miscompares++;
                $display("FAIL reset got %h exp %h", got, pack_exp());
            end
        end
        resetn = 1'b1; start = 1'b0; lanes_req = 2'd0;
    endtask

    task automatic test_sequence();
        start = 1'b1;
        apply();
        vectors++;
        if (got !== pack_exp() || rvfi_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL start got %h exp %h", got, pack_exp());
        end
        start = 1'b0; lanes_req = 2'd2;
        for (int g = 0; g < 3; g++) begin
            apply();
            vectors++;
            if (got !== pack_exp() || rvfi_pc_rdata !== {32'(8*g+4), 32'(8*g)}
                || rvfi_order !== {64'(2*g+1), 64'(2*g)} || rvfi_pc_wdata !== {32'(8*g+8), 32'(8*g+4)}) begin
                miscompares++;
                $display("FAIL seq group %0d got %h exp %h", g, got, pack_exp());
            end
        end
    endtask

    task automatic test_jump();
        lanes_req = 2'd1; jump_req = 1'b1; jump_target = 32'h103;
        apply();
        vectors++;
        if (got !== pack_exp() || rvfi_pc_wdata[31:0] !== 32'h100 || rvfi_valid !== 2'b01) begin
            miscompares++;
            $display("FAIL jump wdata got %h exp %h", got, pack_exp());
        end
        jump_target = 32'h20;
        apply();
        vectors++;
        if (got !== pack_exp() || rvfi_pc_rdata[31:0] !== 32'h100 || rvfi_pc_wdata[31:0] !== 32'h20) begin
            miscompares++;
            $display("FAIL jump follow got %h exp %h", got, pack_exp());
        end
        jump_req = 1'b0;
    endtask

    task automatic test_fault_gap();
        lanes_req = 2'd0; fault_sel = 2'd1; fault_arm = 1'b1;
        apply();
        vectors++;
        if (got !== pack_exp() || rvfi_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL gap arm got %h exp %h", got, pack_exp());
        end
        fault_arm = 1'b0; fault_sel = 2'd0; lanes_req = 2'd1;
        apply();
        vectors++;
        if (got !== pack_exp() || rvfi_pc_rdata[31:0] !== 32'h28 || rvfi_order[63:0] !== 64'd8) begin
            miscompares++;
            $display("FAIL gap lane0 got %h exp %h", got, pack_exp());
        end
        apply();
        vectors++;
        if (got !== pack_exp() || rvfi_pc_rdata[31:0] !== 32'h2C || rvfi_order[63:0] !== 64'd9) begin
            miscompares++;
            $display("FAIL gap clean got %h exp %h", got, pack_exp());
        end
    endtask

    task automatic test_halt();
        lanes_req = 2'd2;
        apply();
        vectors++;
        if (got !== pack_exp() || rvfi_order !== {64'd11, 64'd10} || done !== 1'b0) begin
            miscompares++;
            $display("FAIL halt pre got %h exp %h", got, pack_exp());
        end
        apply();
        vectors++;
        if (got !== pack_exp() || rvfi_valid !== 2'b01 || rvfi_halt !== 2'b01 || rvfi_order[63:0] !== 64'd12) begin
            miscompares++;
            $display("FAIL halt last got %h exp %h", got, pack_exp());
        end
        start = 1'b1;
        for (int c = 0; c < 2; c++) begin
            apply();
            vectors++;
            if (got !== pack_exp() || rvfi_valid !== 2'b00 || done !== 1'b1) begin
                miscompares++;
                $display("FAIL halt sticky got %h exp %h", got, pack_exp());
            end
        end
        start = 1'b0;
    endtask

    task automatic test_order_faults();
        idle_inputs();
        resetn = 1'b0; apply();
        resetn = 1'b1; start = 1'b1; apply();
        start = 1'b0; lanes_req = 2'd2; fault_sel = 2'd2; fault_arm = 1'b1;
        apply();
        vectors++;
        if (got !== pack_exp() || rvfi_order !== {64'd1, 64'd0}) begin
            miscompares++;
            $display("FAIL skip clean got %h exp %h", got, pack_exp());
        end
        fault_arm = 1'b0;
        apply();
        vectors++;
        if (got !== pack_exp() || rvfi_order !== {64'd4, 64'd3}) begin
            miscompares++;
            $display("FAIL skip got %h exp %h", got, pack_exp());
        end
        lanes_req = 2'd0; stall = 1'b1; fault_sel = 2'd3; fault_arm = 1'b1; apply();
        fault_arm = 1'b0; lanes_req = 2'd2; apply();
        stall = 1'b0;
        apply();
        vectors++;
        if (got !== pack_exp() || rvfi_order !== {64'd6, 64'd4}) begin
            miscompares++;
            $display("FAIL dup got %h exp %h", got, pack_exp());
        end
        lanes_req = 2'd0; fault_sel = 2'd1; fault_arm = 1'b1; apply();
        fault_sel = 2'd0; apply();
        fault_arm = 1'b0; lanes_req = 2'd1;
        apply();
        vectors++;
        if (got !== pack_exp() || rvfi_order[63:0] !== 64'd6 || rvfi_pc_rdata[31:0] !== 32'h18) begin
            miscompares++;
            $display("FAIL disarm got %h exp %h", got, pack_exp());
        end
    endtask

    task automatic test_wrap();
        lanes_req = 2'd1; jump_req = 1'b1; jump_target = 32'hFFFF_FFFE;
        apply();
        jump_req = 1'b0; lanes_req = 2'd2;
        apply();
        vectors++;
        if (got !== pack_exp() || rvfi_pc_rdata !== {32'h0, 32'hFFFF_FFFC}
            || rvfi_pc_wdata !== {32'h4, 32'h0} || rvfi_order !== {64'd9, 64'd8}) begin
            miscompares++;
            $display("FAIL wrap got %h exp %h", got, pack_exp());
        end
    endtask

    task automatic test_reset_mid_run();
        idle_inputs();
        resetn = 1'b0; apply();
        resetn = 1'b1; start = 1'b1; apply();
        start = 1'b0; lanes_req = 2'd2; apply();
        resetn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            stall = c[0];
            apply();
            vectors++;
            if (got !== pack_exp() || rvfi_valid !== 2'b00) begin
                miscompares++;
                $display("FAIL midreset got %h exp %h", got, pack_exp());
            end
        end
        resetn = 1'b1; stall = 1'b0; start = 1'b1; apply();
        start = 1'b0; lanes_req = 2'd1;
        apply();
        vectors++;
        if (got !== pack_exp() || rvfi_order[63:0] !== 64'd0 || rvfi_pc_rdata[31:0] !== 32'h0) begin
            miscompares++;
            $display("FAIL restart got %h exp %h", got, pack_exp());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            resetn      = ($urandom_range(0, 39) != 0);
            start       = ($urandom_range(0, 3) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            lanes_req   = 2'($urandom_range(0, 3));
            short_step  = 2'($urandom_range(0, 3));
            jump_req    = ($urandom_range(0, 4) == 0);
            jump_target = $urandom;
            fault_arm   = ($urandom_range(0, 5) == 0);
            fault_sel   = 2'($urandom_range(0, 3));
            apply();
            vectors++;
            if (got !== pack_exp()) begin
                miscompares++;
                $display("FAIL random cycle %0d got %h exp %h", c, got, pack_exp());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_jump();
        test_fault_gap();
        test_halt();
        test_order_faults();
        test_wrap();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
